regs_port_arbiter: RTL and testbench
====================================

# regs_port_arbiter

- Two-master arbiter in front of the PWM register file's single byte-wide access port (read, write, addr, data_write, data_read).
- Lets the host bus bridge (master 0) and an on-chip configuration sequencer (master 1) share register access.
- Round-robin grant, one access in flight at a time.
- Optional lock keeps 16-bit pairs atomic (e.g. compare1 LSB then MSB) against interleaving by the other master.

## Interface

Parameters:
- LOCK_TIMEOUT, 16: idle cycles a lock may be held with no owner request before forced release; 0 disables the timeout.

Ports:
- clk  in  1  peripheral clock
- rst  in  1  asynchronous, active-high reset
- mN_req  in  1  master N (N=0,1) access request; held with command until mN_gnt
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  6  register byte address
- mN_wdata  in  8  write data
- mN_lock  in  1  keep ownership after this access
- mN_gnt  out  1  one-cycle pulse: command accepted
- mN_rvalid  out  1  one-cycle pulse: mN_rdata valid
- mN_rdata  out  8  read data, held until next read completion for that master
- lock_err  out  1  one-cycle pulse: lock released by timeout
- read  out  1  to register file
- write  out  1  to register file
- addr  out  6  to register file
- data_write  out  8  to register file
- data_read  in  8  from register file; valid the cycle after read was high

## Operation

- FSM states: IDLE, ACCESS, RDATA. Every output is registered.

IDLE:
- Samples requests at each edge.
- Eligible set:
  - Lock held: owner only.
  - No lock: both masters.
- With both eligible and both requesting, the master not granted last wins.
- On grant:
  - Latch we/addr/wdata/lock.
  - Next cycle: mN_gnt=1, read or write=1, addr/data_write driven; state ACCESS.
  - Update last-grant pointer.
  - Lock state is set to the winner if its lock=1, cleared if 0.

ACCESS:
- Register file samples at the end of this cycle.
- Write: next state IDLE, read/write deasserted.
- Read: next state RDATA.

RDATA:
- data_read is registered into mN_rdata at the end of this cycle.
- mN_rvalid=1 in the following cycle; state IDLE.

Lock and timeout:
- Lock counter increments each IDLE cycle while a lock is held and the owner is not requesting.
- Counter clears on any owner grant.
- When the counter reaches LOCK_TIMEOUT:
  - Lock cleared, lock_err pulses.
  - Pointer set so the other master wins the next tie.
- Non-owner requests wait (no gnt) while a lock is held.
- Requester rule: the req sampled at the edge ending the gnt cycle is ignored because the FSM is in ACCESS.
  - A requester deasserts req or presents its next command at that edge.
  - That next command is sampled from the next IDLE cycle.
- read and write are never high together. addr/data_write hold their last value when idle.

## Timing

- Reset values (asynchronous, active-high):
  - All outputs 0.
  - State IDLE, lock cleared, lock counter 0.
  - Last-grant pointer = master 1, so master 0 wins the first tie.
- Write: req sampled at edge E1 -> gnt and write high in cycle E1..E2 -> complete.
  - Next request is sampled at E3.
  - Throughput: 1 write per 2 cycles.
- Read: req sampled at E1 -> gnt and read in E1..E2 -> RDATA in E2..E3 -> rvalid and rdata in E3..E4.
  - Latency: 3 cycles.
  - Throughput: 1 read per 3 cycles.
- Reset mid-access: the in-flight read returns no rvalid; the lock is dropped.
- A lock=1 access followed by an owner lock=0 access: the second access is still exclusive; the lock clears at its grant.
- LOCK_TIMEOUT=0: the lock is released only by an owner lock=0 access.

## Test plan

- Single write: m0 writes addr 0x00 data 0xA5 -> write=1 for exactly 1 cycle with addr=0x00, data_write=0xA5; m0_gnt pulses in the same cycle; m1 outputs stay 0.
- Read latency: data_read=0x3C returned for addr 0x0A -> m1_rvalid=1 and m1_rdata=0x3C exactly 3 cycles after the sampling edge of m1_req; read high for 1 cycle only.
- Round-robin: m0 and m1 request continuously with writes -> grants alternate m0, m1, m0, m1 at 2-cycle spacing, starting with m0 after reset.
- Atomic pair: m1 writes 0x03 lock=1 then 0x04 lock=0 while m0 requests throughout -> write accesses at addr 0x03 then 0x04 with no m0 access between; m0 granted next.
- Lock timeout: LOCK_TIMEOUT=4, m0 takes lock then idles, m1 requesting -> lock_err pulses after 4 IDLE cycles; m1_gnt on the following cycle.
- Reset mid-read: assert rst during RDATA -> rvalid never pulses, all outputs 0 immediately, first post-reset tie goes to m0.

Source files
------------

// File: rtl/regs_port_arbiter.sv
// Round-robin arbiter sharing the PWM register file byte port between the host
// bridge (m0) and the config sequencer (m1), with an optional pair lock.
module regs_port_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [5:0] m0_addr,
  input  logic [7:0] m0_wdata,
  input  logic       m0_lock,
  output logic       m0_gnt,
  output logic       m0_rvalid,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [5:0] m1_addr,
  input  logic [7:0] m1_wdata,
  input  logic       m1_lock,
  output logic       m1_gnt,
  output logic       m1_rvalid,
  output logic [7:0] m1_rdata,
  output logic       lock_err,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  localparam int CW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t        state, state_nxt;
  logic          last, last_n;     // master granted most recently
  logic          held, held_n;
  logic          owner, owner_n;
  logic          cur, cur_n;       // master whose access is in flight
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] cnt_inc;

  logic       g0_n, g1_n, rv0_n, rv1_n, lerr_n, read_n, write_n;
  logic [7:0] rd0_n, rd1_n, wd_n;
  logic [5:0] addr_n;
  logic       e0, e1, win, owner_req, win_we;

  always_comb begin
    e0        = m0_req && (!held || !owner);
    e1        = m1_req && (!held || owner);
    win       = (e0 && e1) ? ~last : e1;
    owner_req = owner ? m1_req : m0_req;
    win_we    = win ? m1_we : m0_we;
    cnt_inc   = cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    g0_n      = 1'b0;
    g1_n      = 1'b0;
    rv0_n     = 1'b0;
    rv1_n     = 1'b0;
    lerr_n    = 1'b0;
    read_n    = 1'b0;
    write_n   = 1'b0;
    rd0_n     = m0_rdata;
    rd1_n     = m1_rdata;
    addr_n    = addr;
    wd_n      = data_write;
    last_n    = last;
    held_n    = held;
    owner_n   = owner;
    cur_n     = cur;
    cnt_n     = cnt;
    case (state)
      IDLE: begin
        if (e0 || e1) begin
          state_nxt = ACCESS;
          g0_n      = !win;
          g1_n      = win;
          write_n   = win_we;
          read_n    = !win_we;
          addr_n    = win ? m1_addr : m0_addr;
          wd_n      = win ? m1_wdata : m0_wdata;
          cur_n     = win;
          last_n    = win;
          held_n    = win ? m1_lock : m0_lock;
          owner_n   = win;
          cnt_n     = '0;
        end else if (LOCK_TIMEOUT != 0 && held && !owner_req) begin
          if (cnt_inc == TO) begin
            // Forced release: hand the next tie to the other master.
            held_n = 1'b0;
            lerr_n = 1'b1;
            last_n = owner;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      ACCESS: state_nxt = write ? IDLE : RDATA;
      RDATA: begin
        state_nxt = IDLE;
        if (cur) begin
          rv1_n = 1'b1;
          rd1_n = data_read;
        end else begin
          rv0_n = 1'b1;
          rd0_n = data_read;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      held       <= 1'b0;
      owner      <= 1'b0;
      cur        <= 1'b0;
      cnt        <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      lock_err   <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      data_write <= '0;
    end else begin
      state      <= state_nxt;
      last       <= last_n;
      held       <= held_n;
      owner      <= owner_n;
      cur        <= cur_n;
      cnt        <= cnt_n;
      m0_gnt     <= g0_n;
      m1_gnt     <= g1_n;
      m0_rvalid  <= rv0_n;
      m1_rvalid  <= rv1_n;
      m0_rdata   <= rd0_n;
      m1_rdata   <= rd1_n;
      lock_err   <= lerr_n;
      read       <= read_n;
      write      <= write_n;
      addr       <= addr_n;
      data_write <= wd_n;
    end
  end

endmodule

// File: tb/tb_regs_port_arbiter.sv
// Scoreboard bench for regs_port_arbiter: directed master traffic, expected
// accesses / read returns / lock errors queued with hand-computed cycle numbers.
module tb_regs_port_arbiter;

  logic       clk, rst;
  logic       m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [5:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, lock_err, read, write;
  logic [7:0] m0_rdata, m1_rdata, data_write;
  logic [7:0] data_read;
  logic [5:0] addr;

  regs_port_arbiter #(.LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .lock_err(lock_err), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model behind the port.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (write) mem[addr] <= data_write;
    if (read) data_read <= mem[addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         m;
    bit         we;
    logic [5:0] a;
    logic [7:0] d;
    int         c;
  } ev_t;

  ev_t qa[$];
  ev_t qr[$];
  int  ql[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_acc(input int m, input bit we, input logic [5:0] a,
                         input logic [7:0] d, input int c);
    ev_t e;
    e = '{m, we, a, d, c};
    qa.push_back(e);
  endtask

  task automatic exp_rv(input int m, input logic [7:0] d, input int c);
    ev_t e;
    e = '{m, 1'b0, 6'h0, d, c};
    qr.push_back(e);
  endtask

  function automatic logic [36:0] outs();
    return {m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
            lock_err, read, write, addr, data_write};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until granted, then drop req.
  task automatic do_acc(input int m, input bit we, input logic [5:0] a,
                        input logic [7:0] d, input bit lk);
    bit got;
    got = 1'b0;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lk;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = (m == 0) ? m0_gnt : m1_gnt;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: master %0d got no gnt, required one", m);
    end
    if (m == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
  endtask

  ev_t ea, er;
  always @(negedge clk) begin
    if (read || write || m0_gnt || m1_gnt) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access: got read=%0b write=%0b addr=%0h at cycle %0d, required none",
                 read, write, addr, cyc);
      end else begin
        ea = qa.pop_front();
        chk("acc_cycle", 64'(cyc), 64'(ea.c));
        chk("acc_gnt", {m1_gnt, m0_gnt}, (ea.m == 1) ? 2'b10 : 2'b01);
        chk("acc_cmd", {write, read, addr, ea.we ? data_write : 8'h00},
            {ea.we, !ea.we, ea.a, ea.we ? ea.d : 8'h00});
      end
    end
    if (m0_rvalid || m1_rvalid) begin
      if (qr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got m0=%0b m1=%0b at cycle %0d, required none",
                 m0_rvalid, m1_rvalid, cyc);
      end else begin
        er = qr.pop_front();
        chk("rv_cycle", 64'(cyc), 64'(er.c));
        chk("rv_master", {m1_rvalid, m0_rvalid}, (er.m == 1) ? 2'b10 : 2'b01);
        chk("rv_data", (er.m == 1) ? m1_rdata : m0_rdata, er.d);
      end
    end
    if (lock_err) begin
      if (ql.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_lock_err: got pulse at cycle %0d, required none", cyc);
      end else begin
        chk("lock_err_cycle", 64'(cyc), 64'(ql.pop_front()));
      end
    end
  end

  int b;
  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    repeat (3) tick();
    chk("reset_outs_in_rst", 64'(outs()), 64'h0);
    rst = 1'b0;
    tick();
    chk("reset_outs_after", 64'(outs()), 64'h0);

    // Round-robin from reset: m0 first, then alternating every 2 cycles.
    b = cyc;
    exp_acc(0, 1, 6'h10, 8'h01, b + 1);
    exp_acc(1, 1, 6'h20, 8'h81, b + 3);
    exp_acc(0, 1, 6'h11, 8'h02, b + 5);
    exp_acc(1, 1, 6'h21, 8'h82, b + 7);
    fork
      begin do_acc(0, 1, 6'h10, 8'h01, 0); do_acc(0, 1, 6'h11, 8'h02, 0); end
      begin do_acc(1, 1, 6'h20, 8'h81, 0); do_acc(1, 1, 6'h21, 8'h82, 0); end
    join
    repeat (3) tick();

    // Single write.
    b = cyc;
    exp_acc(0, 1, 6'h00, 8'hA5, b + 1);
    do_acc(0, 1, 6'h00, 8'hA5, 0);
    repeat (3) tick();

    // m0 writes 0x3C to 0x0A, m1 reads it back: 3-cycle latency.
    b = cyc;
    exp_acc(0, 1, 6'h0A, 8'h3C, b + 1);
    exp_acc(1, 0, 6'h0A, 8'h00, b + 3);
    exp_rv(1, 8'h3C, b + 5);
    do_acc(0, 1, 6'h0A, 8'h3C, 0);
    do_acc(1, 0, 6'h0A, 8'h00, 0);
    repeat (5) tick();

    // Atomic pair by m1; m0 waits although it would win the tie.
    b = cyc;
    exp_acc(1, 1, 6'h03, 8'h11, b + 1);
    exp_acc(1, 1, 6'h04, 8'h22, b + 3);
    exp_acc(0, 1, 6'h05, 8'h55, b + 5);
    fork
      begin do_acc(1, 1, 6'h03, 8'h11, 1); do_acc(1, 1, 6'h04, 8'h22, 0); end
      begin tick(); do_acc(0, 1, 6'h05, 8'h55, 0); end
    join
    repeat (3) tick();

    // Lock timeout: m0 locks and goes quiet, m1 waits 4 idle cycles.
    b = cyc;
    exp_acc(0, 1, 6'h06, 8'h66, b + 1);
    ql.push_back(b + 6);
    exp_acc(1, 1, 6'h07, 8'h77, b + 7);
    fork
      do_acc(0, 1, 6'h06, 8'h66, 1);
      begin tick(); do_acc(1, 1, 6'h07, 8'h77, 0); end
    join
    repeat (3) tick();

    // Reset during RDATA of a locked m1 read: no rvalid, lock dropped.
    b = cyc;
    exp_acc(1, 0, 6'h0A, 8'h00, b + 1);
    do_acc(1, 0, 6'h0A, 8'h00, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("reset_mid_read_outs", 64'(outs()), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    b = cyc;
    exp_acc(0, 1, 6'h08, 8'h88, b + 1);
    exp_acc(1, 1, 6'h09, 8'h99, b + 3);
    fork
      do_acc(0, 1, 6'h08, 8'h88, 0);
      do_acc(1, 1, 6'h09, 8'h99, 0);
    join
    repeat (6) tick();

    chk("pending_events", 64'(qa.size() + qr.size() + ql.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
